acf_normalise_buffer: RTL
=========================

// Module: acf_normalise_buffer
// PURPOSE
//  Sits directly downstream of the stage-1 autocorrelation generator. Captures
//  one burst of ORDER+1 64-bit ACF sums (lag 0 first, one per iValid cycle) and
//  derives a common left-shift from lag 0. Re-emits the words as 32-bit
//  normalised fixed point under a valid/ready handshake, feeding the
//  Levinson-Durbin coefficient stage.
// PARAMETERS
//  ORDER  12  highest lag; frame = ORDER+1 words (lags 0..ORDER)
//  IW     64  input ACF width (signed)
//  OW     32  output width (signed); OW < IW
// PORTS
//  iClock     in   1       sole clock, rising edge
//  iReset     in   1       asynchronous, active-low reset
//  iEnable    in   1       0 = freeze all state (inputs ignored, outputs held)
//  iACF       in   IW      signed ACF word, valid with iValid
//  iValid     in   1       one word per high cycle, burst of ORDER+1
//  oACF       out  OW      normalised ACF word
//  oLag       out  4       lag index of oACF (0..ORDER)
//  oValid     out  1       oACF/oLag/oShift valid
//  oLast      out  1       high with the lag==ORDER word
//  iReady     in   1       downstream accepts word when oValid & iReady
//  oShift     out  6       shift applied to the current frame
//  oOverflow  out  1       sticky: input word dropped
// BEHAVIOUR
//  Reset (iReset=0, async): state IDLE; oACF=0, oLag=0, oValid=0, oLast=0,
//   oShift=0, oOverflow=0; word counter 0; partial or pending frame discarded.
//  All updates occur only when iEnable=1; with iEnable=0 nothing changes.
//  FSM:
//   IDLE    - iValid: store word at index 0, cnt=1 -> COLLECT
//   COLLECT - iValid: store at index cnt, cnt++; after word ORDER -> SCAN.
//             iValid low mid-burst is legal (gap); state is held.
//   SCAN    - 1 cycle: if acf0==0 then shift=0, else shift=lzc(acf0)-1 (keeps
//             the sign bit clear, so lag0 normalises into [2^(IW-2), 2^(IW-1)));
//             -> EMIT with lag=0
//   EMIT    - oValid=1; oACF=(acf[lag]<<<shift)[IW-1:IW-OW]; on oValid&iReady:
//             lag++; after the ORDER word, oValid=0 -> IDLE the same edge.
//  Latency: last input word at edge t -> SCAN at t+1 -> oValid=1 after t+2.
//   Minimum frame turnaround = ORDER+1 + 1 + ORDER+1 cycles at iReady=1.
//  Handshake: oACF/oLag/oLast stable while oValid & !iReady; oValid never drops
//   without acceptance (except reset).
//  Overflow: iValid in SCAN or EMIT -> word dropped, oOverflow=1 (sticky to
//   reset). The frame in flight is unaffected.
//  Lags >0 may be negative; the arithmetic shift preserves sign. Because
//   |acf[k]| <= acf0, no lag overflows OW after normalisation.
//  Simultaneous: the final accept in EMIT and iValid on the same edge -> the
//   word is stored at index 0 and the FSM goes to COLLECT (no drop).
//  acf0 < 0 (illegal input): treated as acf0==0 (shift 0, values passed
//   truncated).
// CONFIGURATION
//  ACF_ROUND_EN defined: oACF = round-to-nearest, i.e. truncated value +
//   bit[IW-OW-1] of the shifted word, saturated to +2^(OW-1)-1 on carry-out.
//  ACF_ROUND_EN undefined: plain truncation (floor) of the shifted word.
// TESTING
//  1 acf0=2^40, acf1=2^39, rest 0, iReady=1 -> oShift=22, oACF lag0=0x4000_0000,
//    lag1=0x2000_0000, lag2..12=0; oLast on lag 12; oValid 2 cycles after word 12.
//  2 acf0=0x7FFF_FFFF_FFFF_FFFF, acf1=-1 -> oShift=0, lag0 oACF=0x7FFF_FFFF,
//    lag1 oACF=0xFFFF_FFFF (truncate) / 0x0000_0000 (ACF_ROUND_EN).
//  3 all-zero frame -> oShift=0, 13 words of 0, oLag 0..12.
//  4 iReady toggles 1/0 each cycle -> every word held stable while stalled,
//    13 accepts in 26 cycles, no duplicate or skip.
//  5 iValid pulse during EMIT -> oOverflow=1 and stays 1; emitted frame intact;
//    the next full burst is processed normally.
//  6 iReset low after 5 collected words, then a fresh 13-word burst -> outputs
//    0 during reset; only the fresh frame is emitted, with correct lag indices.

Source files
------------

// File: rtl/acf_normalise_buffer_if.sv
// Output stream of acf_normalise_buffer: normalised ACF words under a
// valid/ready handshake, plus the frame shift and the sticky overflow flag.
// master = producer (the buffer), slave = consumer (coefficient stage).
interface acf_normalise_buffer_if #(
    parameter int unsigned OW = 32
);
    logic [OW-1:0] oACF;
    logic [3:0]    oLag;
    logic          oValid;
    logic          oLast;
    logic          iReady;
    logic [5:0]    oShift;
    logic          oOverflow;

    modport master (
        output oACF, oLag, oValid, oLast, oShift, oOverflow,
        input  iReady
    );

    modport slave (
        input  oACF, oLag, oValid, oLast, oShift, oOverflow,
        output iReady
    );
endinterface

// File: rtl/acf_normalise_buffer.sv
// Captures one burst of ORDER+1 signed ACF sums (lag 0 first), derives a
// common left shift from lag 0 and re-emits every lag as an OW-bit
// normalised word. Define ACF_ROUND_EN for round-to-nearest output;
// otherwise the shifted word is truncated.
module acf_normalise_buffer #(
    parameter int unsigned ORDER = 12,
    parameter int unsigned IW    = 64,
    parameter int unsigned OW    = 32
) (
    input  logic                          iClock,
    input  logic                          iReset,
    input  logic                          iEnable,
    input  logic [IW-1:0]                 iACF,
    input  logic                          iValid,
    acf_normalise_buffer_if.master        norm_bus
);
    localparam int unsigned LZW = $clog2(IW + 1);

    typedef enum logic [1:0] {StIdle, StCollect, StScan, StEmit} state_t;

    state_t        state_q;
    logic [IW-1:0] acf_mem [0:ORDER];
    logic [3:0]    cnt_q;
    logic [3:0]    lag_q;
    logic [OW-1:0] acf_q;
    logic          valid_q;
    logic          last_q;
    logic [5:0]    shift_q;
    logic          overflow_q;

    logic [LZW-1:0] lead_zeros;
    logic [5:0]     scan_shift;
    logic [3:0]     lag_next;
    logic           accept;
    logic           final_accept;

    // Shift the word left and keep its top OW bits (optionally rounded).
    function automatic logic [OW-1:0] normalise(input logic [IW-1:0] word,
                                                input logic [5:0] sh);
        logic [IW-1:0] shifted;
        logic [OW-1:0] trunc;
        shifted = word << sh;
        trunc   = shifted[IW-1 -: OW];
`ifdef ACF_ROUND_EN
        // Only the largest positive value can carry out; hold it there.
        if (shifted[IW-OW-1] && trunc == {1'b0, {(OW-1){1'b1}}}) begin
            normalise = trunc;
        end else begin
            normalise = trunc + OW'(shifted[IW-OW-1]);
        end
`else
        normalise = trunc;
`endif
    endfunction

    // Leading-zero count of lag 0 and the resulting frame shift.
    always_comb begin
        lead_zeros = LZW'(IW);
        for (int unsigned i = 0; i < IW; i++) begin
            if (acf_mem[0][i]) lead_zeros = LZW'(IW - 1 - i);
        end
        // Zero or negative lag 0 gets no shift; otherwise stop one bit short
        // of the sign bit.
        if (acf_mem[0][IW-1] || acf_mem[0] == '0) begin
            scan_shift = '0;
        end else begin
            scan_shift = 6'(lead_zeros - 1'b1);
        end
        lag_next     = lag_q + 4'd1;
        accept       = valid_q && norm_bus.iReady;
        final_accept = accept && last_q;
    end

    // Frame FSM: capture, scan, emit; all outputs registered here.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            lag_q      <= '0;
            acf_q      <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            shift_q    <= '0;
            overflow_q <= 1'b0;
            for (int unsigned i = 0; i <= ORDER; i++) acf_mem[i] <= '0;
        end else if (iEnable) begin
            unique case (state_q)
                StIdle: begin
                    if (iValid) begin
                        acf_mem[0] <= iACF;
                        cnt_q      <= 4'd1;
                        state_q    <= StCollect;
                    end
                end
                StCollect: begin
                    if (iValid) begin
                        acf_mem[cnt_q] <= iACF;
                        if (cnt_q == 4'(ORDER)) begin
                            cnt_q   <= '0;
                            state_q <= StScan;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                StScan: begin
                    if (iValid) overflow_q <= 1'b1;
                    shift_q <= scan_shift;
                    acf_q   <= normalise(acf_mem[0], scan_shift);
                    lag_q   <= '0;
                    valid_q <= 1'b1;
                    last_q  <= 1'b0;
                    state_q <= StEmit;
                end
                StEmit: begin
                    // A word arriving with the final accept opens the next frame.
                    if (iValid && !final_accept) overflow_q <= 1'b1;
                    if (final_accept) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        if (iValid) begin
                            acf_mem[0] <= iACF;
                            cnt_q      <= 4'd1;
                            state_q    <= StCollect;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (accept) begin
                        lag_q  <= lag_next;
                        acf_q  <= normalise(acf_mem[lag_next], shift_q);
                        last_q <= (lag_next == 4'(ORDER));
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign norm_bus.oACF      = acf_q;
    assign norm_bus.oLag      = lag_q;
    assign norm_bus.oValid    = valid_q;
    assign norm_bus.oLast     = last_q;
    assign norm_bus.oShift    = shift_q;
    assign norm_bus.oOverflow = overflow_q;
endmodule
